// File: rtl/hack_mem_pkg.sv
// Shared constants and types for the Hack data-memory responder.
package hack_mem_pkg;

  localparam int unsigned DATA_W = 16;

  localparam logic [DATA_W-1:0] KBD_ADDR_DEF = 16'h6000;
  localparam logic [DATA_W-1:0] OUT_ADDR_DEF = 16'h6001;

  typedef enum logic {
    KBD_EMPTY = 1'b0,
    KBD_FULL  = 1'b1
  } kbd_state_t;

endpackage

// File: rtl/hack_sync_fifo.sv
// Single-clock FIFO; head word is held after the last pop so the sink sees a stable value.
module hack_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    count    = count_q;
    head     = empty ? hold_q : mem_q[rd_ptr_q];
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    hold_d   = head;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end

  // Storage is not reset; entries are always written before they become visible.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/hack_data_mem.sv
// Hack CPU data-memory responder: data RAM, keyboard latch and buffered output port.
module hack_data_mem
  import hack_mem_pkg::*;
#(
  parameter int unsigned       RAM_SIZE   = 32,
  parameter logic [DATA_W-1:0] KBD_ADDR   = KBD_ADDR_DEF,
  parameter logic [DATA_W-1:0] OUT_ADDR   = OUT_ADDR_DEF,
  parameter int unsigned       FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] addressM,
  input  logic [DATA_W-1:0] outM,
  input  logic              writeM,
  output logic [DATA_W-1:0] inM,
  output logic              stall,
  input  logic              key_valid,
  input  logic [DATA_W-1:0] key_data,
  output logic              key_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              bad_addr
);

  localparam int unsigned       AW        = $clog2(RAM_SIZE);
  localparam int unsigned       CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DATA_W-1:0] RAM_LIMIT = DATA_W'(RAM_SIZE);

  logic [DATA_W-1:0] ram_q [RAM_SIZE];
  kbd_state_t        kbd_state_q, kbd_state_d;
  logic [DATA_W-1:0] kbd_latch_q, kbd_latch_d;
  logic              bad_addr_q, bad_addr_d;

  logic              hit_ram, hit_kbd, hit_out, unmapped;
  logic [AW-1:0]     ram_idx;
  logic              ram_we, kbd_wr, fifo_push, fifo_pop;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;

  // Address decode and combinational read mux.
  always_comb begin
    hit_ram   = (addressM < RAM_LIMIT);
    hit_kbd   = (addressM == KBD_ADDR);
    hit_out   = (addressM == OUT_ADDR);
    unmapped  = ~(hit_ram | hit_kbd | hit_out);
    ram_idx   = addressM[AW-1:0];
    stall     = writeM & hit_out & fifo_full;
    ram_we    = writeM & hit_ram & ~reset;
    kbd_wr    = writeM & hit_kbd;
    fifo_push = writeM & hit_out & ~fifo_full;
    fifo_pop  = out_valid & out_ready;
    inM       = '0;
    if (hit_ram)      inM = ram_q[ram_idx];
    else if (hit_kbd) inM = kbd_latch_q;
    else if (hit_out) inM = DATA_W'(fifo_count);
  end

  // Keyboard latch: a key load while empty wins over a coincident consume.
  always_comb begin
    kbd_state_d = kbd_state_q;
    kbd_latch_d = kbd_latch_q;
    bad_addr_d  = bad_addr_q | unmapped;
    case (kbd_state_q)
      KBD_EMPTY: begin
        if (key_valid) begin
          kbd_state_d = KBD_FULL;
          kbd_latch_d = key_data;
        end
      end
      KBD_FULL: begin
        if (kbd_wr) begin
          kbd_state_d = KBD_EMPTY;
          kbd_latch_d = '0;
        end
      end
      default: begin
        kbd_state_d = KBD_EMPTY;
        kbd_latch_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kbd_state_q <= KBD_EMPTY;
      kbd_latch_q <= '0;
      bad_addr_q  <= 1'b0;
    end else begin
      kbd_state_q <= kbd_state_d;
      kbd_latch_q <= kbd_latch_d;
      bad_addr_q  <= bad_addr_d;
    end
  end

  // RAM contents survive reset; only the write is suppressed.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_idx] <= outM;
  end

  assign key_ready = (kbd_state_q == KBD_EMPTY);
  assign bad_addr  = bad_addr_q;
  assign out_valid = ~fifo_empty;

  hack_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (outM),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (out_data)
  );

endmodule

// File: tb/tb_hack_data_mem.sv
// Directed bench for hack_data_mem: RAM, keyboard latch, output FIFO, decode errors.
module tb_hack_data_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic        stall;
  logic        key_valid;
  logic [15:0] key_data;
  logic        key_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        bad_addr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hack_data_mem dut (
    .clk       (clk),
    .reset     (reset),
    .addressM  (addressM),
    .outM      (outM),
    .writeM    (writeM),
    .inM       (inM),
    .stall     (stall),
    .key_valid (key_valid),
    .key_data  (key_data),
    .key_ready (key_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .bad_addr  (bad_addr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [15:0] a, input string tag, input logic [15:0] exp);
    addressM = a;
    #1;
    check(tag, inM, exp);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addressM = a;
    outM     = d;
    writeM   = 1'b1;
    step();
    writeM   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; addressM = '0; outM = '0; writeM = 1'b0;
    key_valid = 1'b0; key_data = '0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    #1;
    check("rst_stall", 16'(stall), 16'd0);
    check("rst_key_ready", 16'(key_ready), 16'd1);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_data", out_data, 16'd0);
    check("rst_bad_addr", 16'(bad_addr), 16'd0);
    rd(16'h6000, "rst_kbd", 16'd0);
    rd(16'h6001, "rst_count", 16'd0);

    // RAM write/read, contents survive reset
    wr(16'd5, 16'd1234);
    wr(16'd0, 16'd77);
    rd(16'd5, "ram5", 16'd1234);
    rd(16'd0, "ram0", 16'd77);
    reset = 1'b1; step(); reset = 1'b0;
    rd(16'd5, "ram5_after_rst", 16'd1234);

    // keyboard load and consume
    key_valid = 1'b1; key_data = 16'd65;
    step();
    key_valid = 1'b0;
    check("kbd_ready_full", 16'(key_ready), 16'd0);
    rd(16'h6000, "kbd_value", 16'd65);
    wr(16'h6000, 16'd999);
    rd(16'h6000, "kbd_consumed", 16'd0);
    check("kbd_ready_empty", 16'(key_ready), 16'd1);

    // output FIFO ordering
    wr(16'h6001, 16'd10);
    wr(16'h6001, 16'd20);
    wr(16'h6001, 16'd30);
    rd(16'h6001, "fifo_count3", 16'd3);
    check("fifo_valid", 16'(out_valid), 16'd1);
    check("fifo_head10", out_data, 16'd10);
    out_ready = 1'b1;
    step(); check("fifo_head20", out_data, 16'd20);
    step(); check("fifo_head30", out_data, 16'd30);
    step();
    out_ready = 1'b0;
    #1;
    check("fifo_drained", 16'(out_valid), 16'd0);
    check("fifo_hold30", out_data, 16'd30);
    rd(16'h6001, "fifo_count0", 16'd0);

    // full FIFO stalls, one pop releases it
    wr(16'h6001, 16'd1);
    wr(16'h6001, 16'd2);
    wr(16'h6001, 16'd3);
    wr(16'h6001, 16'd4);
    rd(16'h6001, "full_count4", 16'd4);
    outM = 16'd5; writeM = 1'b1;
    #1;
    check("full_stall", 16'(stall), 16'd1);
    step();
    check("full_stall_held", 16'(stall), 16'd1);
    check("full_count_held", inM, 16'd4);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    check("stall_released", 16'(stall), 16'd0);
    check("count_after_pop", inM, 16'd3);
    step();
    writeM = 1'b0;
    #1;
    check("fifth_accepted", inM, 16'd4);
    check("head_after_full", out_data, 16'd2);
    out_ready = 1'b1;
    step(); check("drain3", out_data, 16'd3);
    step(); check("drain4", out_data, 16'd4);
    step(); check("drain5", out_data, 16'd5);
    step();
    out_ready = 1'b0;
    #1;
    check("drain_empty", 16'(out_valid), 16'd0);

    // unmapped write and read
    wr(16'h7000, 16'd99);
    check("bad_set_wr", 16'(bad_addr), 16'd1);
    rd(16'h7000, "unmapped_read", 16'd0);
    rd(16'd0, "ram0_untouched", 16'd77);
    rd(16'd5, "ram5_untouched", 16'd1234);
    reset = 1'b1; step(); reset = 1'b0;
    #1;
    check("bad_cleared", 16'(bad_addr), 16'd0);
    addressM = 16'h7fff;
    step();
    addressM = 16'd0;
    #1;
    check("bad_set_rd", 16'(bad_addr), 16'd1);
    reset = 1'b1; step(); reset = 1'b0;
    #1;
    check("bad_cleared2", 16'(bad_addr), 16'd0);

    // simultaneous push/pop and key load vs consume
    wr(16'h6001, 16'd7);
    wr(16'h6001, 16'd8);
    rd(16'h6001, "sim_count2", 16'd2);
    outM = 16'd9; writeM = 1'b1; out_ready = 1'b1;
    step();
    writeM = 1'b0; out_ready = 1'b0;
    #1;
    check("sim_count_kept", inM, 16'd2);
    check("sim_head8", out_data, 16'd8);
    addressM = 16'h6000; outM = 16'd0; writeM = 1'b1;
    key_valid = 1'b1; key_data = 16'd66;
    step();
    writeM = 1'b0;
    key_data = 16'd67;
    step();
    key_valid = 1'b0;
    #1;
    check("sim_kbd_full", 16'(key_ready), 16'd0);
    rd(16'h6000, "sim_kbd_key", 16'd66);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
